// File: rtl/dat_read_block_rx.sv
// Receive-side DAT-line engine of the SD host: waits for the card's start bit,
// deserialises one block on a 1- or 4-bit bus, checks per-line CRC16 and end bit.
module dat_read_block_rx #(
  parameter int unsigned BLOCK_SIZE_WIDTH = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic                        bus_4bit_i,
  input  logic [BLOCK_SIZE_WIDTH-1:0] block_size_i,
  input  logic                        sample_i,
  input  logic [3:0]                  dat_i,
  input  logic                        timeout_i,
  output logic                        running_o,
  output logic                        busy_o,
  output logic [7:0]                  data_o,
  output logic                        data_valid_o,
  output logic                        done_o,
  output logic                        crc_err_o,
  output logic                        end_bit_err_o,
  output logic                        timeout_err_o
);

  localparam int unsigned     LINES    = 4;
  localparam int unsigned     CRC_W    = 16;
  localparam int unsigned     CRC_CNT_W = 4;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_END
  } state_e;

  state_e state_q, state_d;

  logic                             bus_4bit_q, bus_4bit_d;
  logic [BLOCK_SIZE_WIDTH-1:0]      block_size_q, block_size_d;
  logic [BLOCK_SIZE_WIDTH-1:0]      byte_cnt_q, byte_cnt_d;
  logic [2:0]                       bit_cnt_q, bit_cnt_d;
  logic [7:0]                       shift_q, shift_d;
  logic [LINES-1:0][CRC_W-1:0]      crc_q, crc_d;
  logic [CRC_CNT_W-1:0]             crc_cnt_q, crc_cnt_d;
  logic [7:0]                       data_d;
  logic                             data_valid_d, done_d;
  logic                             crc_err_d, end_bit_err_d, timeout_err_d;

  logic [LINES-1:0] active_lines;
  logic [LINES-1:0] crc_msb;
  logic [7:0]       shift_nxt;
  logic             start_bit, byte_done, last_byte;

  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc, input logic b);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

  assign active_lines = bus_4bit_q ? 4'hF : 4'h1;
  assign start_bit    = sample_i && !dat_i[0];
  assign shift_nxt    = bus_4bit_q ? {shift_q[3:0], dat_i} : {shift_q[6:0], dat_i[0]};
  assign byte_done    = bus_4bit_q ? bit_cnt_q[0] : (bit_cnt_q == 3'd7);
  // block_size 0 wraps to all-ones, so the last byte of a 2**W block is matched too
  assign last_byte    = (byte_cnt_q == (block_size_q - BLOCK_SIZE_WIDTH'(1)));

  assign running_o = (state_q == S_WAIT_START);
  assign busy_o    = (state_q != S_IDLE);

  always_comb begin
    crc_msb = '0;
    for (int unsigned l = 0; l < LINES; l++) begin
      crc_msb[l] = crc_q[l][CRC_W-1];
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:       if (start_i) state_d = S_WAIT_START;
        S_WAIT_START: begin
          if (start_bit)      state_d = S_DATA;
          else if (timeout_i) state_d = S_IDLE;
        end
        S_DATA:       if (sample_i && byte_done && last_byte) state_d = S_CRC;
        S_CRC:        if (sample_i && (crc_cnt_q == CRC_CNT_W'(CRC_W - 1))) state_d = S_END;
        S_END:        if (sample_i) state_d = S_IDLE;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    bus_4bit_d    = bus_4bit_q;
    block_size_d  = block_size_q;
    byte_cnt_d    = byte_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    crc_d         = crc_q;
    crc_cnt_d     = crc_cnt_q;
    data_d        = data_o;
    data_valid_d  = 1'b0;
    done_d        = 1'b0;
    crc_err_d     = crc_err_o;
    end_bit_err_d = end_bit_err_o;
    timeout_err_d = timeout_err_o;
    if (!abort_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            bus_4bit_d    = bus_4bit_i;
            block_size_d  = block_size_i;
            crc_err_d     = 1'b0;
            end_bit_err_d = 1'b0;
            timeout_err_d = 1'b0;
          end
        end
        S_WAIT_START: begin
          if (start_bit) begin
            crc_d      = '0;
            byte_cnt_d = '0;
            bit_cnt_d  = '0;
            crc_cnt_d  = '0;
          end else if (timeout_i) begin
            timeout_err_d = 1'b1;
            done_d        = 1'b1;
          end
        end
        S_DATA: begin
          if (sample_i) begin
            shift_d = shift_nxt;
            for (int unsigned l = 0; l < LINES; l++) begin
              crc_d[l] = crc16_step(crc_q[l], dat_i[l]);
            end
            if (byte_done) begin
              data_d       = shift_nxt;
              data_valid_d = 1'b1;
              byte_cnt_d   = byte_cnt_q + BLOCK_SIZE_WIDTH'(1);
              bit_cnt_d    = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        S_CRC: begin
          // Card's CRC arrives MSB first; compare against our MSB and shift out
          if (sample_i) begin
            if (((dat_i ^ crc_msb) & active_lines) != '0) crc_err_d = 1'b1;
            for (int unsigned l = 0; l < LINES; l++) begin
              crc_d[l] = {crc_q[l][CRC_W-2:0], 1'b0};
            end
            crc_cnt_d = crc_cnt_q + CRC_CNT_W'(1);
          end
        end
        S_END: begin
          if (sample_i) begin
            if ((~dat_i & active_lines) != '0) end_bit_err_d = 1'b1;
            done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus_4bit_q    <= 1'b0;
      block_size_q  <= '0;
      byte_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      crc_q         <= '0;
      crc_cnt_q     <= '0;
      data_o        <= '0;
      data_valid_o  <= 1'b0;
      done_o        <= 1'b0;
      crc_err_o     <= 1'b0;
      end_bit_err_o <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      bus_4bit_q    <= bus_4bit_d;
      block_size_q  <= block_size_d;
      byte_cnt_q    <= byte_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      crc_q         <= crc_d;
      crc_cnt_q     <= crc_cnt_d;
      data_o        <= data_d;
      data_valid_o  <= data_valid_d;
      done_o        <= done_d;
      crc_err_o     <= crc_err_d;
      end_bit_err_o <= end_bit_err_d;
      timeout_err_o <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_dat_read_block_rx.sv
// Self-checking bench for dat_read_block_rx: plays the card side of a block read
// and scoreboards received bytes, done pulses and error flags.
module tb_dat_read_block_rx;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, abort_i, bus_4bit_i, sample_i, timeout_i;
  logic [11:0] block_size_i;
  logic [3:0]  dat_i;
  logic        running_o, busy_o, data_valid_o, done_o;
  logic        crc_err_o, end_bit_err_o, timeout_err_o;
  logic [7:0]  data_o;

  dat_read_block_rx #(.BLOCK_SIZE_WIDTH(12)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .bus_4bit_i(bus_4bit_i), .block_size_i(block_size_i), .sample_i(sample_i),
    .dat_i(dat_i), .timeout_i(timeout_i), .running_o(running_o), .busy_o(busy_o),
    .data_o(data_o), .data_valid_o(data_valid_o), .done_o(done_o),
    .crc_err_o(crc_err_o), .end_bit_err_o(end_bit_err_o), .timeout_err_o(timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] blk[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt, run_cnt;
  logic done_crc, done_end, done_to;

  // One clock: drive, advance past the edge, then observe registered outputs
  task automatic cyc(input logic s, input logic [3:0] d);
    sample_i = s;
    dat_i    = d;
    @(posedge clk_i);
    #1;
    sample_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; timeout_i = 1'b0;
    if (data_valid_o) got_q.push_back(data_o);
    if (running_o) run_cnt++;
    if (done_o) begin
      done_cnt++;
      done_crc = crc_err_o;
      done_end = end_bit_err_o;
      done_to  = timeout_err_o;
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Reference CRC of one DAT line over the bytes in blk
  function automatic logic [15:0] model_crc(input int line, input bit bus4);
    logic [15:0] c;
    logic [7:0]  v;
    c = '0;
    for (int i = 0; i < blk.size(); i++) begin
      v = blk[i];
      if (bus4) begin
        c = crc_step(c, v[4 + line]);
        c = crc_step(c, v[line]);
      end else begin
        for (int k = 7; k >= 0; k--) c = crc_step(c, v[k]);
      end
    end
    return c;
  endfunction

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0; run_cnt = 0;
    done_crc = 1'b0; done_end = 1'b0; done_to = 1'b0;
  endtask

  // Card-side driver; sample strobes alternate with gated cycles
  task automatic send_block(input bit bus4, input logic [11:0] bsize,
                            input logic [3:0][15:0] crcs, input bit end_ok,
                            input int abort_after, input bit poke_start);
    logic [7:0] v;
    logic [3:0] d;
    bus_4bit_i = bus4; block_size_i = bsize; start_i = 1'b1;
    cyc(1'b0, 4'hF);
    bus_4bit_i = ~bus4; block_size_i = 12'd3;
    for (int i = 0; i < 3; i++) begin cyc(1'b1, 4'hF); cyc(1'b0, 4'hF); end
    cyc(1'b1, 4'h0);
    for (int i = 0; i < blk.size(); i++) begin
      v = blk[i];
      if (i == abort_after) begin
        cyc(1'b1, {3'b111, v[7]});
        abort_i = 1'b1;
        cyc(1'b1, {3'b111, v[6]});
        for (int j = 0; j < 4; j++) cyc(1'b0, 4'hF);
        return;
      end
      exp_q.push_back(v);
      if (poke_start && i == 1) start_i = 1'b1;
      if (bus4) begin
        cyc(1'b1, v[7:4]); cyc(1'b0, 4'hF);
        cyc(1'b1, v[3:0]); cyc(1'b0, 4'hF);
      end else begin
        for (int k = 7; k >= 0; k--) begin cyc(1'b1, {3'b111, v[k]}); cyc(1'b0, 4'hF); end
      end
    end
    for (int k = 15; k >= 0; k--) begin
      d = bus4 ? {crcs[3][k], crcs[2][k], crcs[1][k], crcs[0][k]} : {3'b111, crcs[0][k]};
      cyc(1'b1, d); cyc(1'b0, 4'hF);
    end
    cyc(1'b1, end_ok ? 4'hF : (bus4 ? 4'h0 : 4'hE));
    for (int j = 0; j < 3; j++) cyc(1'b0, 4'hF);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({running_o, busy_o, data_valid_o, done_o, crc_err_o, end_bit_err_o, timeout_err_o} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000000",
               {running_o, busy_o, data_valid_o, done_o, crc_err_o, end_bit_err_o, timeout_err_o});
    end
    n_cmp++;
    if (data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data_o); end
    rst_ni = 1'b1;
    cyc(1'b0, 4'hF);
  endtask

  task automatic test_1bit_512();
    logic [3:0][15:0] crcs;
    logic [7:0] g, e;
    clear_obs();
    blk.delete();
    for (int i = 0; i < 512; i++) blk.push_back(8'hFF);
    crcs = '0;
    crcs[0] = 16'h7FA1;
    send_block(1'b0, 12'd512, crcs, 1'b1, -1, 1'b0);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL b512_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL b512_byte: got %h want %h", g, e); end
    end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL b512_done: got %0d want 1", done_cnt); end
    n_cmp++;
    if ({done_crc, done_end, done_to} !== 3'b000) begin
      n_err++; $display("FAIL b512_flags: got %b want 000", {done_crc, done_end, done_to});
    end
  endtask

  task automatic test_4bit(input bit flip);
    logic [3:0][15:0] crcs;
    logic [7:0] g, e;
    clear_obs();
    blk = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int l = 0; l < 4; l++) crcs[l] = model_crc(l, 1'b1);
    if (flip) crcs[2][9] = ~crcs[2][9];
    send_block(1'b1, 12'd4, crcs, 1'b1, -1, 1'b0);
    n_cmp++;
    if (got_q.size() != 4) begin n_err++; $display("FAIL b4_count: got %0d want 4", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL b4_byte: got %h want %h", g, e); end
    end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL b4_done: got %0d want 1", done_cnt); end
    n_cmp++;
    if ({done_crc, done_end, done_to} !== {flip, 2'b00}) begin
      n_err++; $display("FAIL b4_flags: got %b want %b", {done_crc, done_end, done_to}, {flip, 2'b00});
    end
  endtask

  task automatic test_end_bit();
    logic [3:0][15:0] crcs;
    logic [7:0] g;
    clear_obs();
    blk = '{8'h5A};
    crcs = '0;
    crcs[0] = model_crc(0, 1'b0);
    send_block(1'b0, 12'd1, crcs, 1'b0, -1, 1'b0);
    n_cmp++;
    g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
    if (g !== 8'h5A) begin n_err++; $display("FAIL eb_byte: got %h want 5a", g); end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL eb_done: got %0d want 1", done_cnt); end
    n_cmp++;
    if ({done_crc, done_end, done_to} !== 3'b010) begin
      n_err++; $display("FAIL eb_flags: got %b want 010", {done_crc, done_end, done_to});
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    bus_4bit_i = 1'b0; block_size_i = 12'd8; start_i = 1'b1;
    cyc(1'b0, 4'hF);
    run_cnt = 0;
    for (int i = 0; i < 100; i++) cyc(i[0], 4'hF);
    timeout_i = 1'b1;
    cyc(1'b1, 4'hF);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'hF);
    n_cmp++;
    if (run_cnt != 100) begin n_err++; $display("FAIL to_running: got %0d cycles want 100", run_cnt); end
    n_cmp++;
    if (running_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL to_idle: got running=%b busy=%b want 0 0", running_o, busy_o);
    end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL to_done: got %0d want 1", done_cnt); end
    n_cmp++;
    if ({done_crc, done_end, done_to} !== 3'b001) begin
      n_err++; $display("FAIL to_flags: got %b want 001", {done_crc, done_end, done_to});
    end
    n_cmp++;
    if (got_q.size() != 0) begin n_err++; $display("FAIL to_data: got %0d bytes want 0", got_q.size()); end
  endtask

  task automatic test_abort();
    logic [3:0][15:0] crcs;
    logic [7:0] g, e;
    clear_obs();
    blk = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    crcs = '0;
    send_block(1'b0, 12'd8, crcs, 1'b1, 3, 1'b0);
    n_cmp++;
    if (done_cnt != 0) begin n_err++; $display("FAIL ab_done: got %0d want 0", done_cnt); end
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL ab_busy: got %b want 0", busy_o); end
    n_cmp++;
    if (got_q.size() != 3) begin n_err++; $display("FAIL ab_count: got %0d want 3", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL ab_byte: got %h want %h", g, e); end
    end
    // Fresh block; a start_i pulse mid-block must be ignored
    clear_obs();
    blk = '{8'hC3, 8'h5A, 8'h0F};
    crcs = '0;
    crcs[0] = model_crc(0, 1'b0);
    send_block(1'b0, 12'd3, crcs, 1'b1, -1, 1'b1);
    n_cmp++;
    if (got_q.size() != 3) begin n_err++; $display("FAIL ab2_count: got %0d want 3", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL ab2_byte: got %h want %h", g, e); end
    end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL ab2_done: got %0d want 1", done_cnt); end
    n_cmp++;
    if ({done_crc, done_end, done_to} !== 3'b000) begin
      n_err++; $display("FAIL ab2_flags: got %b want 000", {done_crc, done_end, done_to});
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL ab2_busy: got %b want 0", busy_o); end
  endtask

  initial begin
    start_i = 1'b0; abort_i = 1'b0; bus_4bit_i = 1'b0; sample_i = 1'b0;
    timeout_i = 1'b0; block_size_i = '0; dat_i = 4'hF;
    test_reset();
    test_1bit_512();
    test_4bit(1'b0);
    test_4bit(1'b1);
    test_end_bit();
    test_timeout();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dat_read_block_rx.md
Name: dat_read_block_rx

Overview:
- Receive-side DAT-line engine of the SD host data path.
- After a read command, waits for the card's start bit and deserialises one data block into bytes on 1-bit or 4-bit bus.
- Checks per-line CRC16 and the end bit, then reports completion.
- Drives the read-timeout counter's running input and consumes its timeout output to abort a start-bit wait that never ends.

Parameters:
- BLOCK_SIZE_WIDTH, 12, width of block_size_i; value 0 means 2**BLOCK_SIZE_WIDTH bytes.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  one-cycle pulse: arm reception of one block
- abort_i  input  1  synchronous abort; returns to IDLE with no done_o
- bus_4bit_i  input  1  1 = DAT[3:0] active, 0 = DAT[0] only; captured on start_i
- block_size_i  input  BLOCK_SIZE_WIDTH  block length in bytes; captured on start_i
- sample_i  input  1  one-cycle strobe: dat_i valid to sample (SD clock rising edge)
- dat_i  input  4  synchronised DAT lines
- timeout_i  input  1  timeout flag from the timeout counter
- running_o  output  1  high while waiting for the start bit (timeout counter enable)
- busy_o  output  1  high in any state other than IDLE
- data_o  output  8  received byte
- data_valid_o  output  1  one-cycle pulse, data_o valid
- done_o  output  1  one-cycle pulse: block finished or timed out
- crc_err_o  output  1  sticky until next start_i: CRC mismatch on any active line
- end_bit_err_o  output  1  sticky until next start_i: end bit not 1 on an active line
- timeout_err_o  output  1  sticky until next start_i: start bit never arrived

Behaviour:
- Reset: state IDLE; all outputs 0; counters, CRC registers and captured config cleared.
- State advance: only on sample_i cycles, except for timeout_i, abort_i and start_i.
- IDLE:
  - start_i: capture config, clear the three error flags, go to WAIT_START.
  - start_i while busy: ignored.
- WAIT_START:
  - running_o = 1, combinationally from state.
  - sample_i && dat_i[0]==0: go to DATA; CRCs cleared to 0; byte counter = 0.
  - timeout_i==1 with no start bit in the same cycle: go to IDLE, set timeout_err_o, pulse done_o.
  - Start bit and timeout_i in the same cycle: start bit wins.
- DATA:
  - 1-bit mode: 8 samples per byte, MSB first from dat_i[0].
  - 4-bit mode: 2 samples per byte, high nibble first, dat_i[3] = bit 7/3.
  - data_o / data_valid_o registered, asserted the cycle after the sample completing the byte.
  - No backpressure.
  - After byte number block_size (0 => 4096): go to CRC.
- CRC16 per active line:
  - Polynomial x^16+x^12+x^5+1, init 0x0000.
  - Each line's CRC is updated with that line's bit on every DATA sample.
  - Inactive lines are ignored.
- CRC state:
  - 16 samples; sample k compares each active line with bit (15-k) of its CRC, MSB first.
  - Any mismatch sets crc_err_o.
  - Go to END.
- END:
  - One sample; any active line ==0 sets end_bit_err_o.
  - Pulse done_o in the cycle after this sample, then go to IDLE.
  - Error flags are valid in the done_o cycle.
- abort_i: has priority over every other event. From any state: go to IDLE; no done_o, no data_valid_o; error flags unchanged.
- sample_i absent: state, counters and CRC hold indefinitely (SD clock gated).
- Reset mid-operation: immediately returns to IDLE; nothing is emitted.

Test Plan:
- 1-bit mode, block_size=512, all bytes 0xFF, card sends CRC 0x7FA1 and end bit 1 -> 512 data_valid_o pulses of 0xFF; done_o once; all error flags 0.
- 4-bit mode, block_size=4, bytes 0x12,0x34,0x56,0x78, correct per-line CRCs -> data_o 0x12,0x34,0x56,0x78 in order; done_o; flags 0.
- Same as the previous case with one bit of line 2's CRC flipped -> crc_err_o=1 at done_o; end_bit_err_o=0.
- 1-bit, block_size=1, end bit driven 0 -> end_bit_err_o=1, crc_err_o=0, done_o pulses.
- start_i, DAT held high, timeout_i raised after 100 cycles -> running_o high for those cycles then 0; timeout_err_o=1; done_o one pulse; no data_valid_o.
- abort_i mid-DATA after 3 bytes, then start_i with a new block -> no done_o for the aborted block; new block received cleanly with flags 0; start_i while busy has no effect.
